// File: rtl/cp0_pkg.sv
// Shared coprocessor-0 definitions: register numbers, field layout, PRId,
// exception handler address and exception codes used by fetch, decode and cp0.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IM_HI     = 15;
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [31:0] PRID_VALUE   = 32'h0000_4D44;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  // Architectural views: unimplemented bits always read as zero.
  function automatic logic [31:0] sr_word(input sr_t s);
    logic [31:0] w;
    w = '0;
    w[SR_IM_HI:SR_IM_LO] = s.im;
    w[SR_EXL]            = s.exl;
    w[SR_IE]             = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input cause_t c);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD]                  = c.bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO]   = c.ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO] = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId register file, mtc0/mfc0 access and the
// exception/interrupt request that redirects fetch to the handler.
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  sr_t         sr_q;
  cause_t      cause_q;
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_target;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    int_req    = (|(HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    exc_req    = (ExcCodeIn != 5'd0) & ~sr_q.exl;
    // Reset masks the request so fetch never redirects while state is being cleared.
    Req        = (int_req | exc_req) & ~reset;
    epc_target = (BDIn ? (VPC - 32'd4) : VPC) & ~32'd3;
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      cause_q.ip <= HWInt;
      if (Req) begin
        // A taken exception swallows any mtc0 or eret issued in the same cycle.
        sr_q.exl         <= 1'b1;
        cause_q.bd       <= BDIn;
        cause_q.exc_code <= int_req ? EXC_INT : ExcCodeIn;
        epc_q            <= epc_target;
      end else begin
        if (en && (CP0Add == CP0_SR)) begin
          sr_q <= '{im: CP0In[SR_IM_HI:SR_IM_LO], exl: CP0In[SR_EXL], ie: CP0In[SR_IE]};
        end
        if (en && (CP0Add == CP0_EPC)) begin
          epc_q <= CP0In;
        end
        if (EXLClr) begin
          sr_q.exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      CP0_SR:    CP0Out = sr_word(sr_q);
      CP0_CAUSE: CP0Out = cause_word(cause_q);
      CP0_EPC:   CP0Out = epc_q;
      CP0_PRID:  CP0Out = PRID_VALUE;
      default:   CP0Out = '0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: each scenario queues expected values as it drives
// stimulus, collects DUT samples, then drains and compares them in order.
module tb_cp0;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  string       exp_name[$];
  logic [31:0] exp_val[$];
  logic [31:0] obs_q[$];
  int          total = 0;
  int          bad   = 0;

  cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .CP0Out    (CP0Out),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en        = 1'b0;
    CP0Add    = '0;
    CP0In     = '0;
    VPC       = '0;
    BDIn      = 1'b0;
    ExcCodeIn = '0;
    HWInt     = '0;
    EXLClr    = 1'b0;
  endtask

  task automatic expect_val(input string name, input logic [31:0] val);
    exp_name.push_back(name);
    exp_val.push_back(val);
  endtask

  task automatic read_reg(input logic [4:0] addr);
    CP0Add = addr;
    #1;
    obs_q.push_back(CP0Out);
  endtask

  task automatic sample_req();
    #1;
    obs_q.push_back({31'd0, Req});
  endtask

  task automatic sample_epcout();
    #1;
    obs_q.push_back(EPCOut);
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; CP0Add = CP0_SR; CP0In = '1;
    ExcCodeIn = EXC_OV; HWInt = 6'h3f; EXLClr = 1'b1; VPC = 32'h0000_1234;
    expect_val("req_before_first_edge", 32'd0); sample_req();
    step(); step();
    expect_val("req_in_reset", 32'd0);      sample_req();
    expect_val("epcout_in_reset", 32'd0);   sample_epcout();
    idle_inputs();
    expect_val("sr_reset", 32'd0);          read_reg(CP0_SR);
    expect_val("cause_reset", 32'd0);       read_reg(CP0_CAUSE);
    expect_val("epc_reset", 32'd0);         read_reg(CP0_EPC);
    expect_val("prid_reset", PRID_VALUE);   read_reg(CP0_PRID);
    step();
    reset = 1'b0;
    step();
    expect_val("req_after_reset", 32'd0);   sample_req();
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  task automatic test_interrupt();
    idle_inputs();
    en = 1'b1; CP0Add = CP0_SR; CP0In = 32'h0000_1401;
    step();
    en = 1'b0; HWInt = 6'b000100; VPC = 32'h0000_3000;
    expect_val("int_req", 32'd1);             sample_req();
    step();
    expect_val("int_cause", 32'h0000_1000);   read_reg(CP0_CAUSE);
    expect_val("int_sr_exl", 32'h0000_1403);  read_reg(CP0_SR);
    expect_val("int_epc", 32'h0000_3000);     read_reg(CP0_EPC);
    expect_val("int_epcout", 32'h0000_3000);  sample_epcout();
    expect_val("int_masked_by_exl", 32'd0);   sample_req();
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  task automatic test_exception();
    idle_inputs();
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    expect_val("eret_sr", 32'h0000_1401);       read_reg(CP0_SR);
    ExcCodeIn = EXC_OV; BDIn = 1'b1; VPC = 32'h0000_3010;
    expect_val("exc_req", 32'd1);               sample_req();
    step();
    ExcCodeIn = EXC_SYSCALL; BDIn = 1'b0; VPC = 32'h0000_4000;
    expect_val("exc_epc_bd", 32'h0000_300C);    read_reg(CP0_EPC);
    expect_val("exc_cause", 32'h8000_0030);     read_reg(CP0_CAUSE);
    expect_val("exc_blocked_by_exl", 32'd0);    sample_req();
    step();
    ExcCodeIn = '0;
    expect_val("exc_epc_hold", 32'h0000_300C);  read_reg(CP0_EPC);
    expect_val("exc_cause_hold", 32'h8000_0030); read_reg(CP0_CAUSE);
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    HWInt = 6'b000001; ExcCodeIn = EXC_RI; VPC = 32'h0000_5007;
    expect_val("prio_req", 32'd1);               sample_req();
    step();
    HWInt = '0; ExcCodeIn = '0;
    expect_val("prio_cause", 32'h0000_0400);     read_reg(CP0_CAUSE);
    expect_val("prio_epc_align", 32'h0000_5004); read_reg(CP0_EPC);
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    EXLClr = 1'b1;
    step();
    en = 1'b1; CP0Add = CP0_EPC; CP0In = 32'h0000_3100;
    ExcCodeIn = EXC_ADEL; VPC = 32'h0000_3020; EXLClr = 1'b1;
    expect_val("coll_req", 32'd1);             sample_req();
    step();
    idle_inputs();
    expect_val("coll_epc", 32'h0000_3020);     read_reg(CP0_EPC);
    expect_val("coll_sr_exl", 32'h0000_1403);  read_reg(CP0_SR);
    expect_val("coll_cause", 32'h0000_0010);   read_reg(CP0_CAUSE);
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  task automatic test_mtc0();
    idle_inputs();
    en = 1'b1; CP0Add = CP0_SR; CP0In = 32'hFFFF_FFFF;
    step();
    en = 1'b0;
    expect_val("mtc0_sr_mask", 32'h0000_FC03);  read_reg(CP0_SR);
    en = 1'b1; CP0Add = CP0_EPC; CP0In = 32'h1235_6787;
    step();
    CP0Add = CP0_CAUSE; CP0In = 32'hFFFF_FFFF;
    step();
    CP0Add = CP0_PRID; CP0In = 32'h0000_0000;
    step();
    en = 1'b0;
    expect_val("mtc0_epc_full", 32'h1235_6787); sample_epcout();
    expect_val("mtc0_cause_ro", 32'h0000_0010); read_reg(CP0_CAUSE);
    expect_val("mtc0_prid_ro", PRID_VALUE);     read_reg(CP0_PRID);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    expect_val("eret_clears_exl", 32'h0000_FC01); read_reg(CP0_SR);
    expect_val("eret_no_req", 32'd0);             sample_req();
    expect_val("mfc0_unmapped7", 32'd0);          read_reg(5'd7);
    expect_val("mfc0_unmapped31", 32'd0);         read_reg(5'd31);
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    ExcCodeIn = EXC_ADES; VPC = 32'h0000_6000;
    expect_val("b2b_first_req", 32'd1);        sample_req();
    step();
    ExcCodeIn = EXC_SYSCALL; VPC = 32'h0000_7000; HWInt = 6'h3f;
    expect_val("b2b_second_req", 32'd0);       sample_req();
    step();
    idle_inputs();
    expect_val("b2b_epc", 32'h0000_6000);      read_reg(CP0_EPC);
    expect_val("b2b_cause", 32'h0000_FC14);    read_reg(CP0_CAUSE);
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  task automatic test_reset_priority();
    idle_inputs();
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    reset = 1'b1; en = 1'b1; CP0Add = CP0_EPC; CP0In = 32'h0000_DEAD;
    HWInt = 6'h01; ExcCodeIn = EXC_OV; EXLClr = 1'b1; VPC = 32'h0000_8000;
    expect_val("rstp_req", 32'd0);          sample_req();
    step();
    idle_inputs();
    expect_val("rstp_sr", 32'd0);           read_reg(CP0_SR);
    expect_val("rstp_cause", 32'd0);        read_reg(CP0_CAUSE);
    expect_val("rstp_epc", 32'd0);          read_reg(CP0_EPC);
    expect_val("rstp_epcout", 32'd0);       sample_epcout();
    reset = 1'b0;
    step();
    while (obs_q.size() != 0) begin
      logic [31:0] o;
      o = obs_q.pop_front();
      total++;
      if (exp_val.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got %h with nothing queued", o);
      end else if (o !== exp_val[0]) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name[0], o, exp_val[0]);
      end
      if (exp_val.size() != 0) begin
        void'(exp_name.pop_front());
        void'(exp_val.pop_front());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_collision();
    test_mtc0();
    test_back_to_back();
    test_reset_priority();
    total++;
    if (exp_val.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d unmatched expectations want 0", exp_val.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
